mult_unit: RTL and testbench
============================

# mult_unit

Iterative shift-add multiplier that executes MIPS MULT/MULTU and owns the HI/LO registers. It sits beside the execute stage and is the producer side of the multiply stall handshake: it consumes the decode-stage multiply request and drives the `MultFinish` stall request back into the hazard unit. That request freezes F, D and E until the 64-bit product is committed to HI/LO.

## Interface
- `WIDTH`, 32, operand width in bits; the product is 2*WIDTH.
- `CNT_W`, $clog2(WIDTH), width of the iteration counter.

Clock and reset are fixed: one clock, synchronous active-high reset.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start_multD`  in  1  a MULT/MULTU is in decode; level signal, held high while decode is stalled.
- `SignedD`  in  1  1 = MULT (signed), 0 = MULTU.
- `SrcAD`  in  WIDTH  multiplicand; already forwarded.
- `SrcBD`  in  WIDTH  multiplier; already forwarded.
- `MultFinish`  out  1  stall request to the hazard unit; high while a multiply is being accepted or computed.
- `HiOut`  out  WIDTH  HI register; upper half of the last product.
- `LoOut`  out  WIDTH  LO register; lower half of the last product.

## Operation
- States: IDLE, BUSY, DONE.
- **IDLE**
  - When `start_multD`=1, latch |SrcAD|, |SrcBD| and `neg` = SignedD & (A[msb]^B[msb]).
  - Clear the 2*WIDTH accumulator and the counter; go to BUSY.
- **BUSY**
  - Each cycle: if multiplier bit0=1, add the multiplicand into the accumulator upper half.
  - Then shift the accumulator and multiplier right by 1, and increment the counter.
  - After WIDTH iterations (counter = WIDTH-1), write {HI,LO} ← `neg` ? -acc : acc and go to DONE.
- **DONE**
  - Lasts exactly one cycle; `start_multD` is ignored; go to IDLE.
  - This lets the stalled MULT leave decode so the same level request does not retrigger the unit.
- `start_multD` is ignored in BUSY and DONE.
- `MultFinish` is combinational: (state==IDLE & start_multD) | (state==BUSY). It is low in DONE.
- HI/LO change only on the BUSY→DONE edge. They are never partially updated.
- Reset in any state: state=IDLE, counter=0, HI=LO=0, `MultFinish`=0.
  - An in-flight multiply is discarded and HI/LO keep the reset value.
- Magnitude of 0x80000000 in signed mode is 0x80000000 as unsigned. No overflow; the product fits in 64 bits.

## Timing
- Start accepted in cycle t, so `MultFinish`=1 in t.
- BUSY occupies cycles t+1 .. t+WIDTH, with `MultFinish`=1.
- HI/LO are valid from cycle t+WIDTH+1 (DONE, `MultFinish`=0).
- Total stall: WIDTH+1 cycles (33 for the default width). Back to IDLE in t+WIDTH+2.
- Back-to-back MULTs: the second request is seen in IDLE at t+WIDTH+2. No lost or duplicated operation.
- An MFHI/MFLO that follows in decode reads the new HI/LO no earlier than t+WIDTH+1, because of the stall.
- The combinational path start_multD→MultFinish is one AND/OR level. No loop through the hazard unit is permitted.

## Configuration
- `MULT_SIGNED_EN`
  - Defined: `SignedD` is honoured, with the magnitude/negate path described above.
  - Undefined: `SignedD` is ignored, all multiplies are unsigned, and the negate logic and sign latch are removed.
  - Undefined does not change latency.

## Structure
- Shared package `mult_pkg`:
  - state enum `mult_state_t` {IDLE, BUSY, DONE}
  - `MULT_FUNCT`=6'b011000 and `MULTU_FUNCT`=6'b011001, for the decoder that generates `start_multD`/`SignedD`.
- One sub-module: `mult_shift_add`, the accumulator/counter datapath: load, step, done-flag.
  - The FSM, sign handling and HI/LO stay in `mult_unit`.

## Test plan
- Reset mid-BUSY (start 7×9, assert reset at iteration 10) → `MultFinish`=0 next cycle, HI=LO=0, state IDLE.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 33 stall cycles, HI=0xFFFFFFFE, LO=0x00000001; `MultFinish` low in DONE.
- MULT −3×5 (with `MULT_SIGNED_EN`) → HI=0xFFFFFFFF, LO=0xFFFFFFF1. Without the macro → HI=0x00000004, LO=0xFFFFFFF1.
- MULT 0x80000000×0x80000000 signed → HI=0x40000000, LO=0.
- Hold `start_multD` high for 40 cycles with 6×7 → exactly two multiplies occur, the second starting at cycle t+34; HI=0, LO=42.
- Start 0×0x12345678 → `MultFinish` high for exactly 33 cycles, HI=LO=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the iterative MULT/MULTU unit and the decoder that drives it.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } mult_state_t;

  localparam logic [5:0] MULT_FUNCT  = 6'b011000;
  localparam logic [5:0] MULTU_FUNCT = 6'b011001;

endpackage

// File: rtl/mult_unit_if.sv
// Decode-side multiply request, stall request back to the hazard unit, and HI/LO read ports.
interface mult_unit_if #(
  parameter int WIDTH = 32
);

  logic             start_multD;
  logic             SignedD;
  logic [WIDTH-1:0] SrcAD;
  logic [WIDTH-1:0] SrcBD;
  logic             MultFinish;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;

  modport master (
    output start_multD, SignedD, SrcAD, SrcBD,
    input  MultFinish, HiOut, LoOut
  );

  modport slave (
    input  start_multD, SignedD, SrcAD, SrcBD,
    output MultFinish, HiOut, LoOut
  );

endinterface

// File: rtl/mult_shift_add.sv
// Shift-add datapath: operand latches, 2*WIDTH accumulator and iteration counter.
module mult_shift_add #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mplier_in,
  output logic               last,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     upper_sum;

  // The add can carry out of the upper half; that carry becomes the new MSB after the shift.
  always_comb begin
    upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]};
    if (mplier[0]) upper_sum = upper_sum + {1'b0, mcand};
    acc_next = {upper_sum, acc[WIDTH-1:1]};
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (step) cnt <= cnt + CNT_W'(1);
  end

  // NOTE: operand and accumulator flops carry no reset; load initialises them before any use.
  always_ff @(posedge clk) begin
    if (load) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/mult_unit.sv
// MULT/MULTU sequencer owning HI/LO; `MULT_SIGNED_EN enables the signed magnitude/negate path.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input logic        clk,
  input logic        reset,
  mult_unit_if.slave bus
);

  mult_state_t        state, state_next;
  logic               load, step, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod_raw, product;
  logic [WIDTH-1:0]   hi, lo;

`ifdef MULT_SIGNED_EN
  logic neg_q;

  // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
  assign mag_a = (bus.SignedD && bus.SrcAD[WIDTH-1]) ? -bus.SrcAD : bus.SrcAD;
  assign mag_b = (bus.SignedD && bus.SrcBD[WIDTH-1]) ? -bus.SrcBD : bus.SrcBD;

  always_ff @(posedge clk) begin
    if (reset)     neg_q <= 1'b0;
    else if (load) neg_q <= bus.SignedD & (bus.SrcAD[WIDTH-1] ^ bus.SrcBD[WIDTH-1]);
  end

  assign product = neg_q ? -prod_raw : prod_raw;
`else
  logic unused_signed;

  assign unused_signed = bus.SignedD;
  assign mag_a         = bus.SrcAD;
  assign mag_b         = bus.SrcBD;
  assign product       = prod_raw;
`endif

  mult_shift_add #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_shift_add (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .mcand_in (mag_a),
    .mplier_in(mag_b),
    .last     (last),
    .acc_next (prod_raw)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    load           = 1'b0;
    step           = 1'b0;
    bus.MultFinish = 1'b0;
    unique case (state)
      IDLE: if (bus.start_multD) begin
        bus.MultFinish = 1'b1;
        load           = 1'b1;
        state_next     = BUSY;
      end
      BUSY: begin
        bus.MultFinish = 1'b1;
        step           = 1'b1;
        if (last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // HI/LO are written in one shot from the final step's result, never piecewise.
  always_ff @(posedge clk) begin
    if (reset)                     {hi, lo} <= '0;
    else if (state == BUSY && last) {hi, lo} <= product;
  end

  assign bus.HiOut = hi;
  assign bus.LoOut = lo;

endmodule

// File: tb/tb_mult_unit.sv
// Directed and randomized checks of mult_unit against an arithmetic reference product.
module tb_mult_unit;

  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mult_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_unit #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [63:0] exp_hilo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic sgn;
`ifdef MULT_SIGNED_EN
    sgn = s;
`else
    sgn = 1'b0 & s;
`endif
    if (sgn) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'b0, a} * {32'b0, b};
  endfunction

  // One MULT issued from decode: request held high through the stall and the DONE cycle.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input string tag);
    int          stall;
    logic [63:0] prev;
    prev            = exp_hilo;
    bus.SrcAD       = a;
    bus.SrcBD       = b;
    bus.SignedD     = s;
    bus.start_multD = 1'b1;
    #1;
    stall = 0;
    while (bus.MultFinish === 1'b1 && stall < 60) begin
      stall++;
      if (stall == 17) check({tag, " hilo_held"}, {bus.HiOut, bus.LoOut}, prev);
      tick();
    end
    check({tag, " stall"}, 64'(stall), 64'd33);
    exp_hilo = exp;
    check({tag, " hilo"}, {bus.HiOut, bus.LoOut}, exp_hilo);
    tick();
    bus.start_multD = 1'b0;
    #1;
    check({tag, " idle"}, 64'(bus.MultFinish), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int          rises, highs, second;
    logic        prev_f;
    logic [31:0] ra, rb;
    logic        rs;

    bus.start_multD = 1'b0;
    bus.SignedD     = 1'b0;
    bus.SrcAD       = '0;
    bus.SrcBD       = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset finish", 64'(bus.MultFinish), 64'd0);
    check("reset hilo", {bus.HiOut, bus.LoOut}, 64'd0);
    tick();

    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "multu_max");
`ifdef MULT_SIGNED_EN
    run_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5");
`else
    run_mult(32'hFFFF_FFFD, 32'd5, 1'b1, 64'h0000_0004_FFFF_FFF1, "mult_neg3x5");
`endif
    run_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "mult_minmin");
    run_mult(32'd0, 32'h1234_5678, 1'b0, 64'd0, "mult_zero");

    // Level request held for 40 cycles: exactly two multiplies, second accepted at t+34.
    bus.SrcAD       = 32'd6;
    bus.SrcBD       = 32'd7;
    bus.SignedD     = 1'b0;
    bus.start_multD = 1'b1;
    prev_f = 1'b0;
    rises  = 0;
    highs  = 0;
    second = -1;
    for (int c = 0; c < 100; c++) begin
      if (c == 40) bus.start_multD = 1'b0;
      #1;
      if (bus.MultFinish && !prev_f) begin
        rises++;
        if (rises == 2) second = c;
      end
      if (bus.MultFinish) highs++;
      prev_f = bus.MultFinish;
      tick();
    end
    check("hold40 starts", 64'(rises), 64'd2);
    check("hold40 second_at", 64'(second), 64'd34);
    check("hold40 stall_cycles", 64'(highs), 64'd66);
    exp_hilo = 64'd42;
    check("hold40 hilo", {bus.HiOut, bus.LoOut}, exp_hilo);

    // Reset at BUSY iteration 10 discards the multiply and clears HI/LO.
    bus.SrcAD       = 32'd7;
    bus.SrcBD       = 32'd9;
    bus.start_multD = 1'b1;
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset           = 1'b0;
    bus.start_multD = 1'b0;
    #1;
    check("midreset finish", 64'(bus.MultFinish), 64'd0);
    exp_hilo = 64'd0;
    check("midreset hilo", {bus.HiOut, bus.LoOut}, exp_hilo);
    tick();
    check("midreset hilo_after", {bus.HiOut, bus.LoOut}, exp_hilo);
    run_mult(32'd7, 32'd9, 1'b0, 64'd63, "after_reset");

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'h8000_0000;
      if (i == 1) rb = 32'hFFFF_FFFF;
      run_mult(ra, rb, rs, model(ra, rb, rs), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
